// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. The host pushes
// bytes one per cycle; a small read FSM (IDLE/REQ/GAP) offers each byte to
// the UART controller with a req/ack handshake.
// Optional feature: define UART_TX_FIFO_OVF_EN to enable the sticky overflow
// flag o_ovf. Without it, o_ovf is tied low and dropped writes are silent.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_flush,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_ovf,
  output logic          o_tx_req,
  input  logic          i_tx_ack,
  output logic [7:0]    o_tx_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_avail;
  state_t        r_state;
  logic          r_tx_req;
  logic [7:0]    r_tx_data;

  logic w_full, w_wr_ok, w_pop;

  assign w_full   = (r_count == L_DEPTH);
  assign w_wr_ok  = i_wr_en & ~w_full;
  assign w_pop    = (r_state == S_REQ) & i_tx_ack;

  assign o_full    = w_full;
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_tx_req  = r_tx_req;
  assign o_tx_data = r_tx_data;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and occupancy. Pointers wrap naturally since DEPTH == 2**AW.
  // r_avail is the non-empty flag one cycle late: it adds the extra cycle of
  // write-to-request latency and is always current by the time the FSM is
  // back in IDLE (a pop is always followed by the GAP cycle).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_avail  <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_avail  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_avail <= (r_count != '0);
    end
  end

  // Read FSM: offer the head byte, hold it until ack, then one idle cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_tx_req  <= 1'b0;
      r_tx_data <= 8'h00;
    end else if (i_flush) begin
      r_state  <= S_IDLE;
      r_tx_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_avail) begin
          r_tx_data <= r_mem[r_rd_ptr];
          r_tx_req  <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: if (i_tx_ack) begin
          r_tx_req <= 1'b0;
          r_state  <= S_GAP;
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;
  // Sticky overflow: set by any write attempted while full, cleared by flush.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)             r_ovf <= 1'b0;
    else if (i_flush)           r_ovf <= 1'b0;
    else if (i_wr_en && w_full) r_ovf <= 1'b1;
  end
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a per-cycle vector table for the
// basic handshake, then hand-written sequences for full/overflow, concurrent
// write+pop, flush, pointer wrap and asynchronous reset. A queue scoreboard
// holds every accepted byte and is compared at each handshake.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [7:0]    i_wr_data = 8'h00;
  logic          i_flush = 1'b0;
  logic          o_full, o_empty, o_ovf, o_tx_req;
  logic [AW:0]   o_level;
  logic          i_tx_ack = 1'b0;
  logic [7:0]    o_tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data), .i_flush(i_flush), .o_full(o_full),
    .o_empty(o_empty), .o_level(o_level), .o_ovf(o_ovf),
    .o_tx_req(o_tx_req), .i_tx_ack(i_tx_ack), .o_tx_data(o_tx_data)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbq[$];
  int m_level = 0;
  bit m_ovf = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       ack;
    logic       e_req;
    logic [7:0] e_data;
    int         e_level;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, update the model, clock, then compare.
  task automatic drive(input logic wr, input logic [7:0] d, input logic ack, input logic fl);
    bit full;
    logic [7:0] exp;
    full = (m_level == DEPTH);
    i_wr_en = wr; i_wr_data = d; i_tx_ack = ack; i_flush = fl;
    if (fl) begin
      sbq.delete(); m_level = 0; m_ovf = 1'b0;
    end else begin
      if (ack && o_tx_req) begin
        if (sbq.size() == 0) check("pop_from_empty_model", 1, 0);
        else begin
          exp = sbq.pop_front();
          check("tx_data_at_ack", o_tx_data, exp);
          m_level--;
        end
      end
      if (wr) begin
        if (!full) begin sbq.push_back(d); m_level++; end
        else if (OVF_ON) m_ovf = 1'b1;
      end
    end
    @(posedge i_clk); #1;
    i_wr_en = 1'b0; i_tx_ack = 1'b0; i_flush = 1'b0;
    check("level", o_level, m_level);
    check("empty", o_empty, m_level == 0);
    check("full", o_full, m_level == DEPTH);
    check("ovf", o_ovf, m_ovf);
  endtask

  task automatic reset_dut();
    i_reset_n = 1'b0; i_wr_en = 1'b0; i_tx_ack = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    sbq.delete(); m_level = 0; m_ovf = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!o_tx_req && n < budget) begin drive(1'b0, 8'h00, 1'b0, 1'b0); n++; end
    check("wait_req_timeout", o_tx_req, 1);
  endtask

  // Drain everything; rnd=1 toggles ack randomly in every state.
  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    logic a;
    while (m_level != 0 && n < budget) begin
      a = rnd ? 1'($urandom_range(0, 1)) : o_tx_req;
      drive(1'b0, 8'h00, a, 1'b0);
      n++;
    end
    check("drain_remaining", sbq.size(), 0);
    check("drain_empty", o_empty, 1);
  endtask

  initial begin
    // Basic single-byte handshake: req two edges after the write, ack three
    // cycles later, ack in GAP and IDLE ignored.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

    // Reset state, sampled while reset is held.
    #3;
    check("rst_req", o_tx_req, 0);
    check("rst_data", o_tx_data, 8'h00);
    check("rst_level", o_level, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_ovf, 0);
    reset_dut();

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].d, tbl[i].ack, 1'b0);
      check($sformatf("tbl%0d_req", i), o_tx_req, tbl[i].e_req);
      check($sformatf("tbl%0d_level", i), o_level, tbl[i].e_level);
      if (tbl[i].e_req) check($sformatf("tbl%0d_data", i), o_tx_data, tbl[i].e_data);
    end

    // Fill to full, drop a 17th byte, drain in order.
    reset_dut();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", o_full, 1);
    check("fill_level", o_level, 16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_level", o_level, 16);
    check("drop_ovf", o_ovf, OVF_ON);
    drain(200, 1'b0);

    // Steady level 5 with simultaneous write and pop.
    reset_dut();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    wait_req(10);
    check("lvl5_before", o_level, 5);
    drive(1'b1, 8'h15, 1'b1, 1'b0);
    check("lvl5_after", o_level, 5);
    wait_req(10);
    check("lvl5_next_data", o_tx_data, 8'h11);
    drain(200, 1'b0);

    // Flush clears overflow; flush beats concurrent write and ack.
    reset_dut();
    for (int i = 0; i < 17; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b1);
    check("flush_ovf", o_ovf, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    wait_req(10);
    check("flush3_level", o_level, 3);
    drive(1'b1, 8'h44, 1'b1, 1'b1);
    check("flush3_req", o_tx_req, 0);
    check("flush3_level_after", o_level, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("flush3_no_req", o_tx_req, 0);
    end

    // Pointer wrap: 12 in, 12 out, 12 in across entry 15, 12 out.
    reset_dut();
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drain(300, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    drain(300, 1'b1);

    // Asynchronous reset mid-REQ at level 4, then fresh latency.
    reset_dut();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    wait_req(10);
    check("pre_rst_req", o_tx_req, 1);
    i_reset_n = 1'b0;
    #2;
    check("async_rst_req", o_tx_req, 0);
    check("async_rst_data", o_tx_data, 8'h00);
    check("async_rst_level", o_level, 0);
    check("async_rst_empty", o_empty, 1);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    sbq.delete(); m_level = 0; m_ovf = 1'b0;
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst_req_n", o_tx_req, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_req_n1", o_tx_req, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_req_n2", o_tx_req, 1);
    check("post_rst_data", o_tx_data, 8'h5A);
    drain(50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count (power of 2, 4..256).
REQ-002 SHALL have parameter AW, default 4, pointer width; log2(DEPTH).
REQ-003 SHALL have port i_clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_en  input  1  host write strobe, one byte per cycle.
REQ-006 SHALL have port i_wr_data  input  8  host write byte.
REQ-007 SHALL have port i_flush  input  1  synchronous FIFO clear.
REQ-008 SHALL have port o_full  output  1  count == DEPTH.
REQ-009 SHALL have port o_empty  output  1  count == 0.
REQ-010 SHALL have port o_level  output  AW+1  current count.
REQ-011 SHALL have port o_ovf  output  1  sticky overflow flag.
REQ-012 SHALL have port o_tx_req  output  1  send request to the UART controller.
REQ-013 SHALL have port i_tx_ack  input  1  one-cycle ack from the UART controller; byte accepted.
REQ-014 SHALL have port o_tx_data  output  8  byte offered to the UART controller.

Function
REQ-015 SHALL store bytes in DEPTH-entry circular buffer; write/read pointers AW bits, wrap DEPTH-1 -> 0; count AW+1 bits.
REQ-016 SHALL, on i_wr_en with o_full=0, write i_wr_data at wr_ptr and increment wr_ptr; count updates at the same edge.
REQ-017 SHALL, on i_wr_en with o_full=1, drop the byte (no pointer/count change), even if a pop occurs that cycle.
REQ-018 SHALL, on simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-019 SHALL drive o_full, o_empty, o_level combinationally from registered count.
REQ-020 SHALL run read FSM states IDLE, REQ, GAP.
REQ-021 IDLE: if count != 0, load o_tx_data <= mem[rd_ptr], set o_tx_req <= 1, go REQ; else stay.
REQ-022 REQ: hold o_tx_req=1 and o_tx_data stable until i_tx_ack=1; on ack: rd_ptr++, count--, o_tx_req <= 0, go GAP.
REQ-023 GAP: one cycle with o_tx_req=0, then IDLE.
REQ-024 SHALL ignore i_tx_ack in IDLE and GAP.
REQ-025 Latency: byte written on edge N into empty FIFO -> o_tx_req high after edge N+2; back-to-back bytes spaced by ack + 2 cycles minimum.
REQ-026 SHALL, on i_flush=1, zero pointers and count, force FSM IDLE, o_tx_req <= 0, clear o_ovf; i_flush overrides i_wr_en and i_tx_ack the same cycle; an offered byte is abandoned.

Reset
REQ-027 SHALL, on i_reset_n low (asynchronous), force o_tx_req=0, o_tx_data=8'h00, o_ovf=0, pointers/count=0, FSM IDLE; hence o_empty=1, o_full=0, o_level=0.
REQ-028 SHALL NOT reset storage array contents.
REQ-029 SHALL drop any in-flight request if reset asserts in REQ; first request after release follows REQ-025.

Configuration
REQ-030 SHALL gate overflow detection with macro UART_TX_FIFO_OVF_EN.
REQ-031 With UART_TX_FIFO_OVF_EN defined: o_ovf <= 1 on any dropped write (REQ-017); held until i_flush or reset.
REQ-032 Without UART_TX_FIFO_OVF_EN: o_ovf tied 0; dropping behaviour unchanged.

Verification
REQ-033 Reset, then write 8'hA5 at edge N, ack 3 cycles after req -> o_tx_req rises after edge N+2, o_tx_data=8'hA5 stable until ack, o_level 1->0, o_empty=1.
REQ-034 Write 16 bytes 8'h00..8'h0F with no ack -> o_full=1, o_level=16; 17th write 8'hFF dropped, o_ovf=1 (macro on) / 0 (macro off); acking drains 8'h00..8'h0F in order, no 8'hFF.
REQ-035 Hold FIFO at level 5, write and ack same cycle -> o_level stays 5, next offered byte is the following entry.
REQ-036 Level 3, o_tx_req high, assert i_flush with i_wr_en and i_tx_ack -> next cycle o_tx_req=0, o_level=0, o_ovf=0, no new request.
REQ-037 Fill 12, drain 12, fill 12 (wrap past entry 15) -> output order equals input order across the pointer wrap.
REQ-038 Assert i_reset_n low mid-REQ at level 4 -> o_tx_req=0, o_tx_data=8'h00, o_level=0 immediately, without a clock edge.
